// File: rtl/bitrev_addr_gen.sv
// Bit/digit-reversed address sweep generator for NTT/NWC stages.
// Walks 0..2^W-1 and streams each index with its reversed counterpart over valid/ready.
module bitrev_addr_gen #(
  parameter int unsigned D_WIDTH    = 12,
  parameter int unsigned RADIX_BITS = 2,
  parameter int unsigned MAX_L      = 6,
  parameter int unsigned L_WIDTH    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [L_WIDTH-1:0] l,
  input  logic               mode,
  output logic               busy,
  output logic               cfg_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_idx,
  output logic [D_WIDTH-1:0] out_rev,
  output logic               out_last,
  output logic               done
);

  localparam int unsigned C_WIDTH = D_WIDTH + 1;
  localparam int unsigned I_WIDTH = $clog2(D_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_d;
  logic [L_WIDTH-1:0]   l_q, l_d;
  logic                 mode_q, mode_d;
  logic [C_WIDTH-1:0]   cnt, cnt_d;
  logic [C_WIDTH-1:0]   span;
  logic [D_WIDTH-1:0]   cnt_rev;
  logic                 cfg_ok;
  logic                 busy_d, cfg_err_d, valid_d, last_d, done_d;
  logic [D_WIDTH-1:0]   idx_d, rev_d;

  // Bit i of idx lands at its mirrored position inside the low W bits; bits >= W stay 0.
  function automatic logic [D_WIDTH-1:0] reverse(input logic [D_WIDTH-1:0] idx,
                                                 input logic [L_WIDTH-1:0] digits,
                                                 input logic digit_mode);
    int unsigned w;
    int unsigned nd;
    int unsigned pos;
    logic [D_WIDTH-1:0] r;
    nd = 32'(digits);
    w  = RADIX_BITS * nd;
    r  = '0;
    for (int unsigned i = 0; i < D_WIDTH; i++) begin
      if (i < w) begin
        if (digit_mode)
          pos = (nd - 1 - i / RADIX_BITS) * RADIX_BITS + i % RADIX_BITS;
        else
          pos = w - 1 - i;
        r[I_WIDTH'(pos)] = idx[I_WIDTH'(i)];
      end
    end
    return r;
  endfunction

  assign cnt_rev = reverse(cnt[D_WIDTH-1:0], l_q, mode_q);
  assign span    = C_WIDTH'(1) << (RADIX_BITS * 32'(l_q));
  assign cfg_ok  = (l != '0) && (32'(l) <= MAX_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      l_q       <= '0;
      mode_q    <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_rev   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      l_q       <= l_d;
      mode_q    <= mode_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      cfg_err   <= cfg_err_d;
      out_valid <= valid_d;
      out_idx   <= idx_d;
      out_rev   <= rev_d;
      out_last  <= last_d;
      done      <= done_d;
    end
  end

  // Next-state and registered-output logic; a load happens when the slot is free and cnt < 2^W.
  always_comb begin
    state_d   = state;
    l_d       = l_q;
    mode_d    = mode_q;
    cnt_d     = cnt;
    busy_d    = (state == RUN);
    cfg_err_d = 1'b0;
    valid_d   = out_valid;
    idx_d     = out_idx;
    rev_d     = out_rev;
    last_d    = out_last;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = RUN;
            l_d     = l;
            mode_d  = mode;
            cnt_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_valid && out_ready && out_last) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if ((!out_valid || out_ready) && (cnt != span)) begin
          valid_d = 1'b1;
          idx_d   = cnt[D_WIDTH-1:0];
          rev_d   = cnt_rev;
          last_d  = (cnt == span - C_WIDTH'(1));
          cnt_d   = cnt + C_WIDTH'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
